// File: rtl/operand_fetch.sv
// operand_fetch: decode/operand-fetch stage with a busy-bit scoreboard, optional
// writeback bypass and a one-deep valid/ready output register.
module operand_fetch #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] out_rs1,
  output logic [31:0] out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_rd_en
);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  logic [6:0]  opc;
  logic [4:0]  rd;
  logic        rd_en, uses_rs1, uses_rs2, hazard, accept;
  logic [31:0] wb_clr, byp, flush_clr, acc_set;
  logic [31:0] busy_q, busy_d;
  logic        out_valid_q, out_valid_d, out_rd_en_q, out_rd_en_d;
  logic [31:0] out_pc_q, out_pc_d, out_inst_q, out_inst_d;
  logic [31:0] out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
  logic [4:0]  out_rd_q, out_rd_d;
  always_comb begin
    opc       = in_inst[6:0];
    rd        = in_inst[11:7];
    rs1_addr  = in_inst[19:15];
    rs2_addr  = in_inst[24:20];
    rd_en     = opc != OP_BRANCH && opc != OP_STORE && rd != 5'd0;
    uses_rs1  = opc != OP_LUI && opc != OP_AUIPC && opc != OP_JAL;
    uses_rs2  = opc == OP_BRANCH || opc == OP_STORE || opc == OP_OP;
    wb_clr    = (wb_en && wb_addr != 5'd0) ? 32'd1 << wb_addr : 32'd0;
    byp       = BYPASS ? wb_clr : 32'd0;
    hazard    = (uses_rs1 && busy_q[rs1_addr] && !byp[rs1_addr]) ||
                (uses_rs2 && busy_q[rs2_addr] && !byp[rs2_addr]) ||
                (rd_en && busy_q[rd] && !byp[rd]);
    // No in_valid term: in_ready must not depend combinationally on it.
    in_ready  = !rst && !flush && !hazard && (!out_valid_q || out_ready);
    accept    = in_valid && in_ready;
    flush_clr = (flush && out_valid_q && out_rd_en_q) ? 32'd1 << out_rd_q : 32'd0;
    acc_set   = (accept && rd_en) ? 32'd1 << rd : 32'd0;
    busy_d    = ((busy_q & ~flush_clr & ~wb_clr) | acc_set) & 32'hFFFF_FFFE;
    out_valid_d = flush ? 1'b0 : accept ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
    out_pc_d    = accept ? in_pc : out_pc_q;
    out_inst_d  = accept ? in_inst : out_inst_q;
    out_rd_d    = accept ? rd : out_rd_q;
    out_rd_en_d = accept ? rd_en : out_rd_en_q;
    out_rs1_d   = !accept ? out_rs1_q : byp[rs1_addr] ? wb_data : rs1_addr == 5'd0 ? 32'd0 : rs1_data;
    out_rs2_d   = !accept ? out_rs2_q : byp[rs2_addr] ? wb_data : rs2_addr == 5'd0 ? 32'd0 : rs2_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_rd_q    <= '0;
      out_rd_en_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_rd_q    <= out_rd_d;
      out_rd_en_q <= out_rd_en_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;
  assign out_rs1   = out_rs1_q;
  assign out_rs2   = out_rs2_q;
  assign out_rd    = out_rd_q;
  assign out_rd_en = out_rd_en_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed checks on a no-bypass instance, then randomized traffic
// on a bypass instance checked by a queue scoreboard against a reference model.
module tb_operand_fetch;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 0, in_ready, wb_en = 0, flush = 0, out_valid, out_ready = 0, out_rd_en;
  logic [31:0] in_inst = 0, in_pc = 0, rs1_data = 0, rs2_data = 0, wb_data = 0;
  logic [31:0] out_pc, out_inst, out_rs1, out_rs2;
  logic [4:0]  rs1_addr, rs2_addr, wb_addr = 0, out_rd;

  logic        nb_in_valid = 0, nb_in_ready, nb_wb_en = 0, nb_flush = 0, nb_out_valid, nb_out_ready = 0, nb_out_rd_en;
  logic [31:0] nb_in_inst = 0, nb_in_pc = 0, nb_rs1_data = 0, nb_rs2_data = 0, nb_wb_data = 0;
  logic [31:0] nb_out_pc, nb_out_inst, nb_out_rs1, nb_out_rs2;
  logic [4:0]  nb_rs1_addr, nb_rs2_addr, nb_wb_addr = 0, nb_out_rd;

  operand_fetch #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_en(out_rd_en));

  operand_fetch #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .in_valid(nb_in_valid), .in_ready(nb_in_ready), .in_inst(nb_in_inst), .in_pc(nb_in_pc),
    .rs1_addr(nb_rs1_addr), .rs2_addr(nb_rs2_addr), .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
    .wb_en(nb_wb_en), .wb_addr(nb_wb_addr), .wb_data(nb_wb_data), .flush(nb_flush),
    .out_valid(nb_out_valid), .out_ready(nb_out_ready), .out_pc(nb_out_pc), .out_inst(nb_out_inst),
    .out_rs1(nb_out_rs1), .out_rs2(nb_out_rs2), .out_rd(nb_out_rd), .out_rd_en(nb_out_rd_en));

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc, inst, a, b;
    logic [4:0]  rd;
    logic        rd_en;
  } exp_t;
  exp_t q[$];

  localparam logic [6:0] BR = 7'b1100011, ST = 7'b0100011, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111, OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011, JALR = 7'b1100111;
  logic [6:0] opcs [9] = '{BR, ST, LUI, AUIPC, JAL, OP, OPI, LD, JALR};

  // Reference model state for the bypass instance
  logic [31:0] mbusy = 0;
  logic        mval = 0, m_rd_en = 0, hold = 0;
  logic [4:0]  m_rd = 0;

  function automatic logic [31:0] gen_inst();
    logic [4:0] a, b, d;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    return {7'($urandom), b, a, 3'($urandom), d, opcs[$urandom_range(0, 8)]};
  endfunction

  function automatic bit clr(input logic [4:0] r);
    return wb_en && wb_addr == r && r != 0;
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r, input logic [31:0] d);
    return clr(r) ? wb_data : (r == 0) ? 32'd0 : d;
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid) begin
        if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          chk("out_pc", out_pc, q[0].pc);
          chk("out_inst", out_inst, q[0].inst);
          chk("out_rs1", out_rs1, q[0].a);
          chk("out_rs2", out_rs2, q[0].b);
          chk("out_rd", out_rd, q[0].rd);
          chk("out_rd_en", out_rd_en, q[0].rd_en);
          if (flush || out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [6:0] opc;
    logic [4:0] r1, r2, rd;
    logic       rden, u1, u2, hz, erdy, acc;
    logic [31:0] nbusy;
    // Directed scenarios on the no-bypass instance
    step(); step();
    rst = 0; nb_in_valid = 1; nb_in_inst = 32'h00500093; nb_in_pc = 0; nb_out_ready = 1;
    @(negedge clk); chk("nb_addi_ready", nb_in_ready, 1);
    step(); nb_in_inst = 32'h00108133; nb_in_pc = 4;
    @(negedge clk);
    chk("nb_addi_valid", nb_out_valid, 1);
    chk("nb_addi_rd", nb_out_rd, 1);
    chk("nb_addi_rd_en", nb_out_rd_en, 1);
    chk("nb_raw_stall", nb_in_ready, 0);
    step(); nb_wb_en = 1; nb_wb_addr = 1; nb_wb_data = 5;
    @(negedge clk); chk("nb_wb_cycle_stall", nb_in_ready, 0);
    step(); nb_wb_en = 0; nb_rs1_data = 5; nb_rs2_data = 5;
    @(negedge clk); chk("nb_after_wb_ready", nb_in_ready, 1);
    step(); nb_in_inst = 32'h00000033; nb_in_pc = 8; nb_rs1_data = 32'hDEADBEEF; nb_rs2_data = 32'hDEADBEEF; nb_out_ready = 0;
    @(negedge clk);
    chk("nb_add_rs1", nb_out_rs1, 5);
    chk("nb_add_rs2", nb_out_rs2, 5);
    chk("nb_add_rd", nb_out_rd, 2);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      @(negedge clk);
      chk("nb_bp_ready", nb_in_ready, 0);
      chk("nb_bp_hold_pc", nb_out_pc, 4);
      chk("nb_bp_hold_rs1", nb_out_rs1, 5);
    end
    step(); nb_out_ready = 1;
    @(negedge clk); chk("nb_b2b_ready", nb_in_ready, 1);
    step(); nb_in_inst = 32'h00100193; nb_in_pc = 12;
    @(negedge clk);
    chk("nb_x0_rs1", nb_out_rs1, 0);
    chk("nb_x0_rd_en", nb_out_rd_en, 0);
    chk("nb_x0_nostall", nb_in_ready, 1);
    step(); nb_in_valid = 0; nb_out_ready = 0; nb_flush = 1;
    @(negedge clk);
    chk("nb_flush_held", nb_out_inst, 32'h00100193);
    chk("nb_flush_ready", nb_in_ready, 0);
    step(); nb_flush = 0; nb_in_valid = 1; nb_in_inst = 32'h00318233; nb_in_pc = 16; nb_out_ready = 1;
    @(negedge clk);
    chk("nb_flush_valid", nb_out_valid, 0);
    chk("nb_flush_busy_clr", nb_in_ready, 1);
    step(); nb_in_inst = 32'h00100293; nb_in_pc = 20;
    @(negedge clk); chk("nb_addi5_ready", nb_in_ready, 1);
    step(); nb_in_valid = 0; nb_out_ready = 0; rst = 1;
    @(negedge clk);
    chk("nb_rst_ready", nb_in_ready, 0);
    chk("nb_pre_rst_valid", nb_out_valid, 1);
    step(); rst = 0; nb_in_valid = 1; nb_in_inst = 32'h00528333; nb_in_pc = 24; nb_out_ready = 1;
    @(negedge clk);
    chk("nb_rst_valid", nb_out_valid, 0);
    chk("nb_rst_data", {nb_out_pc, nb_out_inst, nb_out_rs1, nb_out_rs2}, 0);
    chk("nb_rst_rd", {nb_out_rd, nb_out_rd_en}, 0);
    chk("nb_rst_busy_clr", nb_in_ready, 1);
    step(); nb_in_valid = 0;

    // Randomized traffic on the bypass instance
    for (int i = 0; i < 3004; i++) begin
      step();
      if (!hold) begin
        in_valid = ($urandom % 4) != 0;
        in_inst = gen_inst();
        in_pc = $urandom & ~32'd3;
      end
      rs1_data = $urandom; rs2_data = $urandom;
      wb_en = ($urandom % 10) < 4;
      case ($urandom % 3)
        0: wb_addr = in_inst[19:15];
        1: wb_addr = in_inst[11:7];
        default: wb_addr = 5'($urandom_range(0, 7));
      endcase
      wb_data = $urandom;
      flush = ($urandom % 20) == 0;
      rst = (i == 0) || ($urandom % 200) == 0;
      out_ready = ($urandom % 4) != 0;
      if (i >= 3000) begin
        in_valid = 0; flush = 0; rst = 0; out_ready = 1;
      end
      @(negedge clk);
      opc = in_inst[6:0]; rd = in_inst[11:7]; r1 = in_inst[19:15]; r2 = in_inst[24:20];
      rden = !(opc inside {BR, ST}) && rd != 0;
      u1 = !(opc inside {LUI, AUIPC, JAL});
      u2 = opc inside {BR, ST, OP};
      hz = (u1 && mbusy[r1] && !clr(r1)) || (u2 && mbusy[r2] && !clr(r2)) || (rden && mbusy[rd] && !clr(rd));
      erdy = !rst && !flush && !hz && (!mval || out_ready);
      acc = in_valid && erdy;
      if (i > 0) begin
        chk("in_ready", in_ready, erdy);
        chk("out_valid", out_valid, mval);
        chk("rs_addr", {rs1_addr, rs2_addr}, {r1, r2});
      end
      if (acc) q.push_back('{in_pc, in_inst, opnd(r1, rs1_data), opnd(r2, rs2_data), rd, rden});
      hold = in_valid && !in_ready;
      nbusy = mbusy;
      if (flush && mval && m_rd_en) nbusy[m_rd] = 0;
      if (wb_en && wb_addr != 0) nbusy[wb_addr] = 0;
      if (acc && rden) nbusy[rd] = 1;
      mval = flush ? 1'b0 : acc ? 1'b1 : (mval && out_ready) ? 1'b0 : mval;
      if (acc) begin m_rd = rd; m_rd_en = rden; end
      mbusy = nbusy;
      if (rst) begin
        mbusy = 0; mval = 0; q.delete();
      end
    end
    step();
    chk("drain_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode/operand-fetch pipeline stage of the rv32 core. It sits directly upstream of the register file. It accepts instructions from fetch, drives the register file read addresses, and resolves read-after-write and write-after-write hazards with a 31-entry busy-bit scoreboard and an optional writeback bypass. It delivers captured operands to execute through a one-deep valid/ready output register.

## Interface
- BYPASS, 1, when 1 a same-cycle writeback to a source register forwards `wb_data` and unblocks the stall; when 0 the stage waits one extra cycle.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_inst  in  word_t  instruction word.
- in_pc  in  word_t  instruction address.
- rs1_addr  out  addr_t  register file read port 1 address; equals in_inst[19:15].
- rs2_addr  out  addr_t  register file read port 2 address; equals in_inst[24:20].
- rs1_data  in  word_t  register file read data 1 (combinational).
- rs2_data  in  word_t  register file read data 2 (combinational).
- wb_en  in  1  writeback commit this cycle (same signal as the register file write enable).
- wb_addr  in  addr_t  writeback destination.
- wb_data  in  word_t  writeback value.
- flush  in  1  discard the instruction held in the output register.
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  execute consumes this cycle.
- out_pc, out_inst  out  word_t  captured pc and instruction.
- out_rs1, out_rs2  out  word_t  captured operands.
- out_rd  out  addr_t  destination register (in_inst[11:7]).
- out_rd_en  out  1  instruction writes a nonzero rd.

## Operation
- Decode uses opcode = inst[6:0].
  - rd_en = opcode not BRANCH (1100011) and not STORE (0100011), and rd ≠ 0.
  - uses_rs1 = opcode not LUI (0110111), AUIPC (0010111) or JAL (1101111).
  - uses_rs2 = opcode is BRANCH, STORE or OP (0110011).
- The scoreboard has busy[1..31]. busy[0] is constantly 0.
- clr(r) is true when wb_en && wb_addr == r && r ≠ 0.
- A source register r is blocked when it is used and busy[r] is set, unless BYPASS = 1 and clr(r).
- WAW: when rd_en, rd is blocked if busy[rd] is set, unless BYPASS = 1 and clr(rd).
- hazard = rs1 blocked, or rs2 blocked, or rd blocked.
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
- accept = in_valid && in_ready. On accept:
  - all out_* fields load;
  - out_valid is set;
  - busy[rd] is set if rd_en.
- Operand select: the operand is wb_data if BYPASS and clr(rs); 0 if rs = 0; otherwise rs*_data.
- When out_valid && out_ready && !accept, out_valid clears.
- Scoreboard update priority, highest first:
  - set on accept;
  - clear on wb;
  - clear on flush.
  - A set and a clear of the same index in one cycle leave the bit set.
- Flush:
  - out_valid clears.
  - If out_valid && out_rd_en, busy[out_rd] clears.
  - No instruction is accepted that cycle.
- Reset:
  - out_valid = 0, all busy = 0.
  - out_pc, out_inst, out_rs1, out_rs2 = 0; out_rd = 0; out_rd_en = 0.
  - in_ready = 0 while rst is high.
  - Reset asserted mid-stall discards all state.

## Timing
- Latency: accept in cycle N, out_valid in cycle N+1.
- Throughput: 1 instruction per cycle with no hazards and out_ready held high.
- The output holds stable while out_valid && !out_ready. Operands do not re-sample while held.
- A write to the register file lands at the clock edge, so a same-cycle read returns the old value. The bypass covers this case.
- With BYPASS = 0, a dependent instruction accepts at the earliest in the cycle after the wb_en cycle.
- in_ready, rs1_addr and rs2_addr are combinational from in_inst, busy, wb_* and the output state. There is no combinational path from in_valid to in_ready.
- in_valid/in_ready follow AXI-style rules: the producer holds its inputs while in_valid && !in_ready.

## Test plan
- Reset then stream: inject ADDI x1,x0,5 (0x00500093) at pc 0x0 with out_ready = 1.
  - out_valid rises 1 cycle later with out_rd = 1 and out_rd_en = 1.
  - busy[1] = 1 until wb_en with wb_addr = 1.
- RAW stall: the ADDI x1 is in flight and ADD x2,x1,x1 (0x00108133) is offered.
  - in_ready = 0 until wb_en=1, wb_addr=1, wb_data=5.
  - With BYPASS = 1, accept happens in that cycle and out_rs1 = out_rs2 = 5.
  - With BYPASS = 0, accept happens the next cycle.
- Backpressure: hold out_ready = 0 for 3 cycles after accept.
  - out_* stay constant and in_ready = 0.
  - out_ready = 1 plus a new in_valid gives back-to-back transfer.
- x0 handling: ADD x0,x0,x0 with rs1_data = 0xDEADBEEF.
  - out_rs1 = 0 and out_rd_en = 0.
  - No busy bit is set and no stall occurs.
- Flush: the output holds ADDI x3 (busy[3] = 1); assert flush.
  - out_valid = 0 next cycle and busy[3] = 0.
  - A following ADD x4,x3,x3 accepts without stall.
- Reset mid-operation: assert rst while busy[5] = 1 and out_valid = 1.
  - All busy bits, out_valid and all data outputs = 0 after one edge.
  - in_ready = 0 while rst = 1.
